// File: rtl/pedestrian_signal_array.sv
// Multi-crossing pedestrian signal controller.
// Each of N_XING channels runs its own request / WALK / flashing DON'T WALK /
// clearance sequence against a per-channel grant from the vehicle controller.
// A global preempt input aborts active crossings and holds idle channels off.
// Every output is driven directly from a flop.
module pedestrian_signal_array #(
  parameter int N_XING      = 2,
  parameter int WALK_TICKS  = 7,
  parameter int FLASH_TICKS = 12,
  parameter int CLEAR_TICKS = 3,
  parameter int CNT_W       = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    preempt,
  input  logic [N_XING-1:0]       button,
  input  logic [N_XING-1:0]       grant,
  output logic [N_XING-1:0]       req,
  output logic [N_XING-1:0]       walk,
  output logic [N_XING-1:0]       dont_walk,
  output logic [N_XING*CNT_W-1:0] countdown,
  output logic [N_XING-1:0]       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WALK,
    S_FLASH,
    S_CLEAR
  } state_e;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_TICKS);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_TICKS);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_TICKS);

  for (genvar g = 0; g < N_XING; g++) begin : g_xing
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cd_q, cd_d;
    logic             latch_q, latch_d;
    logic             req_q, req_d;
    logic             walk_q, walk_d;
    logic             dw_q, dw_d;
    logic             done_q, done_d;
    logic             go_clear;

    // Next-state and next-output logic for one crossing.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cd_d     = cd_q;
      latch_d  = latch_q;
      req_d    = req_q;
      walk_d   = walk_q;
      dw_d     = dw_q;
      done_d   = 1'b0;
      go_clear = 1'b0;

      // The button is remembered everywhere except while WALK is already lit.
      if (state_q != S_WALK && button[g]) latch_d = 1'b1;

      case (state_q)
        S_IDLE: begin
          if (!preempt && (latch_q || button[g])) begin
            state_d = S_REQ;
            req_d   = 1'b1;
          end
        end
        S_REQ: begin
          if (preempt) begin
            // Withdraw the request but keep the latched button for later.
            state_d = S_IDLE;
            req_d   = 1'b0;
          end else if (grant[g]) begin
            // A tick coinciding with the grant is deliberately not counted.
            state_d = S_WALK;
            cnt_d   = WALK_LD;
            cd_d    = '0;
            walk_d  = 1'b1;
            dw_d    = 1'b0;
            latch_d = 1'b0;
          end
        end
        S_WALK: begin
          if (preempt) begin
            go_clear = 1'b1;
          end else if (tick) begin
            if (cnt_q == ONE) begin
              state_d = S_FLASH;
              cnt_d   = FLASH_LD;
              cd_d    = FLASH_LD;
              walk_d  = 1'b0;
              dw_d    = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        S_FLASH: begin
          if (preempt) begin
            go_clear = 1'b1;
          end else if (tick) begin
            if (cnt_q == ONE) begin
              go_clear = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
              cd_d  = cnt_q - ONE;
              dw_d  = ~dw_q;
            end
          end
        end
        S_CLEAR: begin
          // Preempt has no effect here: clearance always runs to completion.
          if (tick) begin
            if (cnt_q == ONE) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              req_d   = 1'b0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
          walk_d  = 1'b0;
          dw_d    = 1'b1;
          cd_d    = '0;
          cnt_d   = '0;
        end
      endcase

      // Common entry into the solid DON'T WALK clearance phase.
      if (go_clear) begin
        state_d = S_CLEAR;
        cnt_d   = CLEAR_LD;
        cd_d    = '0;
        walk_d  = 1'b0;
        dw_d    = 1'b1;
      end
    end

    // State, counter, latch and registered outputs for one crossing.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        cd_q    <= '0;
        latch_q <= 1'b0;
        req_q   <= 1'b0;
        walk_q  <= 1'b0;
        dw_q    <= 1'b1;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        cd_q    <= cd_d;
        latch_q <= latch_d;
        req_q   <= req_d;
        walk_q  <= walk_d;
        dw_q    <= dw_d;
        done_q  <= done_d;
      end
    end

    assign req[g]                      = req_q;
    assign walk[g]                     = walk_q;
    assign dont_walk[g]                = dw_q;
    assign done[g]                     = done_q;
    assign countdown[g*CNT_W +: CNT_W] = cd_q;
  end

endmodule

// File: tb/tb_pedestrian_signal_array.sv
// Bench for pedestrian_signal_array: directed scenarios plus a randomized run,
// all compared cycle by cycle against a phase/elapsed-tick reference model.
module tb_pedestrian_signal_array;

  localparam int N  = 2;
  localparam int W  = 5;
  localparam int WT = 7;
  localparam int FT = 12;
  localparam int CT = 3;
  localparam int VW = 4*N + N*W;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_WALK  = 2;
  localparam int P_FLASH = 3;
  localparam int P_CLEAR = 4;

  localparam logic [VW-1:0] RESET_VEC =
    {{N{1'b0}}, {N{1'b0}}, {N{1'b1}}, {(N*W){1'b0}}, {N{1'b0}}};

  logic           clk     = 1'b0;
  logic           reset_n = 1'b0;
  logic           tick    = 1'b0;
  logic           preempt = 1'b0;
  logic [N-1:0]   button  = '0;
  logic [N-1:0]   grant   = '0;
  logic [N-1:0]   req, walk, dont_walk, done;
  logic [N*W-1:0] countdown;
  logic [VW-1:0]  dut_vec;
  logic [W-1:0]   cd0, cd1;

  assign dut_vec = {req, walk, dont_walk, countdown, done};
  assign cd0     = countdown[0 +: W];
  assign cd1     = countdown[W +: W];

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference model: phase plus ticks elapsed within that phase.
  int m_phase [N];
  int m_el    [N];
  bit m_latch [N];
  bit m_done  [N];

  pedestrian_signal_array #(
    .N_XING     (N),
    .WALK_TICKS (WT),
    .FLASH_TICKS(FT),
    .CLEAR_TICKS(CT),
    .CNT_W      (W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick     (tick),
    .preempt  (preempt),
    .button   (button),
    .grant    (grant),
    .req      (req),
    .walk     (walk),
    .dont_walk(dont_walk),
    .countdown(countdown),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_phase[i] = P_IDLE;
      m_el[i]    = 0;
      m_latch[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
  endfunction

  function automatic void model_step(input logic [N-1:0] b, input logic [N-1:0] g,
                                     input logic t, input logic p);
    for (int i = 0; i < N; i++) begin
      int ph;
      int el;
      int len;
      bit la;
      ph = m_phase[i];
      el = m_el[i];
      la = m_latch[i];
      m_done[i] = 1'b0;
      if (ph != P_WALK && b[i]) m_latch[i] = 1'b1;
      case (ph)
        P_IDLE: if (!p && (la || b[i])) m_phase[i] = P_REQ;
        P_REQ: begin
          if (p) m_phase[i] = P_IDLE;
          else if (g[i]) begin
            m_phase[i] = P_WALK;
            m_el[i]    = 0;
            m_latch[i] = 1'b0;
          end
        end
        P_WALK, P_FLASH: begin
          len = (ph == P_WALK) ? WT : FT;
          if (p) begin
            m_phase[i] = P_CLEAR;
            m_el[i]    = 0;
          end else if (t) begin
            if (el + 1 == len) begin
              m_phase[i] = ph + 1;
              m_el[i]    = 0;
            end else m_el[i] = el + 1;
          end
        end
        P_CLEAR: begin
          if (t) begin
            if (el + 1 == CT) begin
              m_phase[i] = P_IDLE;
              m_el[i]    = 0;
              m_done[i]  = 1'b1;
            end else m_el[i] = el + 1;
          end
        end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [N-1:0]   r, w, d, dn;
    logic [N*W-1:0] c;
    r = '0; w = '0; d = '0; dn = '0; c = '0;
    for (int i = 0; i < N; i++) begin
      r[i]  = (m_phase[i] != P_IDLE);
      w[i]  = (m_phase[i] == P_WALK);
      d[i]  = !((m_phase[i] == P_WALK) || (m_phase[i] == P_FLASH && (m_el[i] % 2) == 1));
      dn[i] = m_done[i];
      if (m_phase[i] == P_FLASH) c[i*W +: W] = W'(FT - m_el[i]);
    end
    return {r, w, d, c, dn};
  endfunction

  // Drive one clock of stimulus, advance the model at the edge, settle.
  task automatic apply(input logic [N-1:0] b, input logic [N-1:0] g,
                       input logic t, input logic p);
    button  = b;
    grant   = g;
    tick    = t;
    preempt = p;
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step(b, g, t, p);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    apply('0, '0, 1'b0, 1'b0);
    apply('0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    if (dut_vec !== RESET_VEC) begin
      n_miss++;
      $display("FAIL reset_values dut=%h want=%h", dut_vec, RESET_VEC);
    end
    n_vec++;
  endtask

  task automatic test_single();
    int k, walk_ticks, clear_ticks, exp_cd;
    logic t, pw, pr, seen_flash, got_done;
    logic [W-1:0] pc;
    walk_ticks = 0; clear_ticks = 0; exp_cd = FT; seen_flash = 0; got_done = 0; k = 0;
    do_reset();
    apply(2'b01, 2'b00, 1'b0, 1'b0);
    if (req[0] !== 1'b1) begin
      n_miss++; $display("FAIL req_after_button dut=%b want=1", req[0]);
    end
    n_vec++;
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    while (!got_done && k < 400) begin
      t = (cyc % 4 == 0);
      pw = walk[0]; pr = req[0]; pc = cd0;
      apply(2'b00, 2'b01, t, 1'b0);
      if (pw && t) walk_ticks++;
      if (seen_flash && pr && pc == '0 && t) clear_ticks++;
      if (cd0 != '0 && cd0 != pc) begin
        seen_flash = 1'b1;
        if (cd0 !== W'(exp_cd)) begin
          n_miss++; $display("FAIL flash_countdown dut=%0d want=%0d", cd0, exp_cd);
        end
        n_vec++;
        exp_cd--;
      end
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_single cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
      if ({req[1], walk[1], dont_walk[1], cd1, done[1]} !== {3'b001, W'(0), 1'b0}) begin
        n_miss++; $display("FAIL ch1_idle cyc=%0d dut=%b%b%b_%0d_%b want=001_0_0",
                           cyc, req[1], walk[1], dont_walk[1], cd1, done[1]);
      end
      n_vec++;
      if (done[0]) begin
        got_done = 1'b1;
        if (req[0] !== 1'b0) begin
          n_miss++; $display("FAIL req_drop_at_done dut=%b want=0", req[0]);
        end
        n_vec++;
      end
      k++;
    end
    if (!got_done) begin n_miss++; $display("FAIL single_timeout done never seen"); end
    n_vec++;
    if (walk_ticks != WT) begin
      n_miss++; $display("FAIL walk_ticks dut=%0d want=%0d", walk_ticks, WT);
    end
    n_vec++;
    if (exp_cd != 0) begin
      n_miss++; $display("FAIL flash_steps remaining=%0d want=0", exp_cd);
    end
    n_vec++;
    if (clear_ticks != CT) begin
      n_miss++; $display("FAIL clear_ticks dut=%0d want=%0d", clear_ticks, CT);
    end
    n_vec++;
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    if (done[0] !== 1'b0) begin
      n_miss++; $display("FAIL done_one_clk dut=%b want=0", done[0]);
    end
    n_vec++;
  endtask

  task automatic test_button_hold();
    int k, walk_ticks;
    logic t, pw, b, got_done, pulsed;
    // Part 1: button held into WALK then released: no re-request afterwards.
    do_reset();
    k = 0; walk_ticks = 0; b = 1'b1; got_done = 1'b0;
    while (!got_done && k < 400) begin
      t = (cyc % 4 == 0);
      pw = walk[0];
      apply({1'b0, b}, {1'b0, k >= 2}, t, 1'b0);
      if (pw && t) walk_ticks++;
      if (walk_ticks >= 4) b = 1'b0;
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_hold cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
      got_done = done[0];
      k++;
    end
    if (!got_done) begin n_miss++; $display("FAIL hold_timeout done never seen"); end
    n_vec++;
    repeat (12) begin
      apply(2'b00, 2'b00, (cyc % 4 == 0), 1'b0);
      if (req[0] !== 1'b0) begin
        n_miss++; $display("FAIL no_rerequest cyc=%0d dut=%b want=0", cyc, req[0]);
      end
      n_vec++;
    end
    // Part 2: a button pulse during FLASH re-requests one clk after done.
    k = 0; got_done = 1'b0; pulsed = 1'b0;
    while (!got_done && k < 400) begin
      t = (cyc % 4 == 0);
      b = (k == 0) || (!pulsed && cd0 == W'(6));
      if (k != 0 && b) pulsed = 1'b1;
      apply({1'b0, b}, {1'b0, k >= 2}, t, 1'b0);
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_relatch cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
      got_done = done[0];
      k++;
    end
    if (!got_done || !pulsed) begin n_miss++; $display("FAIL relatch_timeout done=%b pulsed=%b", got_done, pulsed); end
    n_vec++;
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    if (req[0] !== 1'b1) begin
      n_miss++; $display("FAIL rerequest_after_done dut=%b want=1", req[0]);
    end
    n_vec++;
  endtask

  task automatic test_preempt();
    int k, ticks;
    logic t, pressed, got_done;
    logic [1:0] b;
    do_reset();
    k = 0; pressed = 1'b0;
    while (cd0 != W'(8) && k < 200) begin
      t = (cyc % 4 == 0);
      b = {(cd0 != '0) && !pressed, (k == 0)};
      if (b[1]) pressed = 1'b1;
      apply(b, {1'b0, k >= 2}, t, 1'b0);
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_prep cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
      k++;
    end
    if (k >= 200) begin n_miss++; $display("FAIL preempt_setup_timeout cd0=%0d", cd0); end
    if (req[1] !== 1'b1) begin
      n_miss++; $display("FAIL ch1_req_before_preempt dut=%b want=1", req[1]);
    end
    n_vec++;
    apply(2'b00, 2'b01, 1'b0, 1'b1);
    if ({req[0], walk[0], dont_walk[0], cd0} !== {3'b101, W'(0)}) begin
      n_miss++; $display("FAIL ch0_preempt_clear dut=%b%b%b_%0d want=101_0",
                         req[0], walk[0], dont_walk[0], cd0);
    end
    n_vec++;
    if (req[1] !== 1'b0) begin
      n_miss++; $display("FAIL ch1_preempt_drop dut=%b want=0", req[1]);
    end
    n_vec++;
    ticks = 0;
    repeat (5) begin
      t = (cyc % 4 == 0);
      apply(2'b00, 2'b01, t, 1'b1);
      if (t) ticks++;
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_preempt cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
    end
    t = (cyc % 4 == 0);
    apply(2'b00, 2'b01, t, 1'b0);
    if (t) ticks++;
    if (req[1] !== 1'b1) begin
      n_miss++; $display("FAIL ch1_rerequest dut=%b want=1", req[1]);
    end
    n_vec++;
    got_done = done[0]; k = 0;
    while (!got_done && k < 100) begin
      t = (cyc % 4 == 0);
      apply(2'b00, 2'b01, t, 1'b0);
      if (t) ticks++;
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_postpre cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
      got_done = done[0];
      k++;
    end
    if (!got_done) begin n_miss++; $display("FAIL preempt_timeout done never seen"); end
    if (ticks != CT) begin
      n_miss++; $display("FAIL preempt_clear_ticks dut=%0d want=%0d", ticks, CT);
    end
    n_vec++;
  endtask

  task automatic test_simultaneous();
    int k;
    logic t, got_done;
    do_reset();
    apply(2'b11, 2'b00, 1'b0, 1'b0);
    k = 0; got_done = 1'b0;
    while (!got_done && k < 400) begin
      t = (cyc % 4 == 0);
      apply(2'b00, 2'b11, t, 1'b0);
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_simul cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
      if (walk[0] !== walk[1] || dont_walk[0] !== dont_walk[1] || cd0 !== cd1) begin
        n_miss++; $display("FAIL lockstep cyc=%0d ch0=%b%b_%0d ch1=%b%b_%0d",
                           cyc, walk[0], dont_walk[0], cd0, walk[1], dont_walk[1], cd1);
      end
      n_vec++;
      if (done != 2'b00) begin
        got_done = 1'b1;
        if (done !== 2'b11) begin
          n_miss++; $display("FAIL both_done dut=%b want=11", done);
        end
        n_vec++;
      end
      k++;
    end
    if (!got_done) begin n_miss++; $display("FAIL simul_timeout done never seen"); end
  endtask

  task automatic test_grant_drop();
    int k, ticks, walk_ticks;
    logic t, sw, pw, g, got_done;
    do_reset();
    k = 0; ticks = 0; walk_ticks = 0; sw = 1'b0; g = 1'b0; got_done = 1'b0;
    while (!got_done && k < 400) begin
      t = (cyc % 4 == 0);
      pw = sw;
      if (k == 2) g = 1'b1;
      if (walk_ticks >= 2) g = 1'b0;
      apply({1'b0, k == 0}, {1'b0, g}, t, 1'b0);
      if (pw && t) ticks++;
      if (pw && t && walk[0]) walk_ticks++;
      if (walk[0]) sw = 1'b1;
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_gdrop cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
      got_done = done[0];
      k++;
    end
    if (!got_done) begin n_miss++; $display("FAIL gdrop_timeout done never seen"); end
    if (ticks != WT + FT + CT) begin
      n_miss++; $display("FAIL gdrop_total_ticks dut=%0d want=%0d", ticks, WT + FT + CT);
    end
    n_vec++;
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(2'b11, 2'b00, 1'b0, 1'b0);
    apply(2'b10, 2'b01, 1'b0, 1'b0);
    repeat (5) apply(2'b00, 2'b01, (cyc % 4 == 0), 1'b0);
    if (walk[0] !== 1'b1 || req[1] !== 1'b1) begin
      n_miss++; $display("FAIL async_setup walk0=%b req1=%b want=1,1", walk[0], req[1]);
    end
    n_vec++;
    reset_n = 1'b0;
    model_reset();
    #2;
    if (dut_vec !== RESET_VEC) begin
      n_miss++; $display("FAIL async_reset_immediate dut=%h want=%h", dut_vec, RESET_VEC);
    end
    n_vec++;
    apply(2'b00, 2'b00, 1'b0, 1'b0);
    reset_n = 1'b1;
    repeat (6) begin
      apply(2'b00, 2'b00, (cyc % 4 == 0), 1'b0);
      if (req !== 2'b00) begin
        n_miss++; $display("FAIL latch_lost cyc=%0d dut=%b want=00", cyc, req);
      end
      n_vec++;
    end
  endtask

  task automatic test_random();
    logic [N-1:0] b, g;
    logic t, p;
    do_reset();
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        b[i] = ($urandom_range(0, 7) == 0);
        g[i] = ($urandom_range(0, 2) != 0);
      end
      t = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 29) == 0);
      apply(b, g, t, p);
      if (dut_vec !== model_vec()) begin
        n_miss++; $display("FAIL model_random cyc=%0d dut=%h ref=%h", cyc, dut_vec, model_vec());
      end
      n_vec++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_button_hold();
    test_preempt();
    test_simultaneous();
    test_grant_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pedestrian_signal_array.md
Name: pedestrian_signal_array

Overview:
- Parametrised, multi-crossing successor to the single pedestrian signal.
- Drives N_XING independent crosswalk heads. Each head has its own FSM.
- Each head latches its push-button and requests a slot from the vehicle traffic controller with a req/grant handshake.
- Each head sequences WALK, flashing DON'T WALK with a numeric countdown, then an all-stop clearance. A global preempt input (emergency vehicle) aborts every crossing.

Parameters:
- N_XING, 2, number of crossing channels (1..8).
- WALK_TICKS, 7, tick periods of solid WALK (>=1).
- FLASH_TICKS, 12, tick periods of flashing DON'T WALK with countdown (>=1).
- CLEAR_TICKS, 3, tick periods of solid DON'T WALK clearance before release (>=1).
- CNT_W, 5, countdown/counter width. Every *_TICKS value must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk timebase strobe (nominally 1 Hz); all timing counts ticks.
- preempt  in  1  synchronous emergency override, level.
- button  in  N_XING  push-button per crossing, level, already synchronised.
- grant  in  N_XING  traffic controller grants crossing i; held high until done[i].
- req  out  N_XING  crossing i requests/holds its slot.
- walk  out  N_XING  WALK lamp.
- dont_walk  out  N_XING  DON'T WALK lamp (solid or flashing).
- countdown  out  N_XING*CNT_W  remaining FLASH ticks; channel i occupies bits [i*CNT_W +: CNT_W].
- done  out  N_XING  one-clk pulse when crossing i releases its slot.

Behaviour:
- Reset (async, reset_n=0): all channels enter IDLE.
  - req=0, walk=0, dont_walk=1, countdown=0, done=0, button latch=0, counters=0.
- All outputs are registered.
- Button latch: set by button=1 in any state except WALK; ignored in WALK. Cleared on the REQ->WALK transition.
- IDLE: outputs are dont_walk=1, walk=0, req=0.
  - If latch set (or button=1 this cycle) and preempt=0 -> REQ next clk. req=1 is registered with the state change.
- REQ: req=1.
  - grant=1 -> WALK next clk; counter loaded with WALK_TICKS.
  - A tick arriving in the same cycle as grant is not counted.
- WALK: walk=1, dont_walk=0, countdown=0, req=1.
  - Counter decrements on each tick.
  - Tick with counter==1 -> FLASH; counter and countdown loaded with FLASH_TICKS; dont_walk=1 (phase on).
- FLASH: walk=0, req=1.
  - dont_walk toggles on each tick. countdown tracks the counter.
  - Tick with counter==1 -> CLEAR; counter loaded with CLEAR_TICKS; countdown=0; dont_walk=1 solid.
- CLEAR: dont_walk=1 solid, walk=0, req=1.
  - Tick with counter==1 -> IDLE; done=1 for exactly that following clk; req=0.
  - A latch set during FLASH/CLEAR re-enters REQ on the clk after IDLE is entered.
- Grant deassertion before done is ignored. A grant while in IDLE/CLEAR is ignored.
- Preempt (priority over all channel events):
  - WALK or FLASH -> CLEAR next clk; counter=CLEAR_TICKS, countdown=0, dont_walk=1, walk=0.
  - REQ -> IDLE with req=0, latch retained, no done pulse.
  - CLEAR completes normally and emits done.
  - While preempt=1, IDLE does not leave IDLE; buttons still latch.
  - Preempt while already in CLEAR does not reload the counter.
- Channels are fully independent; simultaneous grants are legal. Safety interlock between conflicting crossings is the traffic controller's job.
- Reset asserted mid-sequence: immediate return to reset values, latches lost.

Test Plan:
- Reset, then button[0] pulse 1 clk, grant[0]=1 two clks later, tick every 4 clks:
  - req[0] high the clk after the button.
  - walk[0]=1 for 7 ticks.
  - countdown[0] steps 12,11..1 with dont_walk[0] toggling per tick.
  - 3 ticks of solid dont_walk, then done[0] pulses 1 clk and req[0]=0.
  - Channel 1 stays at reset values throughout.
- Button held high through WALK then released:
  - No re-request after done.
  - A button pulse during FLASH -> req re-asserts 1 clk after done.
- Preempt=1 mid-FLASH on ch0 while ch1 is in REQ:
  - ch0 goes to CLEAR next clk, countdown=0, done after 3 ticks.
  - ch1 req drops, latch kept; ch1 re-requests the clk after preempt falls.
- Both channels granted the same clk: identical, independent timing, with both done pulses in the same clk.
- Grant dropped during WALK: sequence completes unchanged.
- reset_n pulsed low mid-WALK with no clk edge: outputs return to reset values immediately.
